// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath with a single shared memory port.
// Outputs are registered from the next state; irwrite/pcwrite in FETCH are qualified by memready.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       immzext,
  output logic       regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       halted,
  output logic [1:0] errcode
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX,
    S_RTYPE_WB, S_BEQ, S_IMM_EX, S_IMM_WB, S_LUI_WB, S_JUMP, S_HALT
  } state_e;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       fetch;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       immzext;
    logic       regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam ctrl_t CTRL_FETCH = '{memreq: 1'b1, fetch: 1'b1, alusrcb: 2'b01,
                                   alucontrol: 3'b010, default: '0};

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] err_q, err_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       mem_state;
  logic       unused_zero;

  // Branch resolution happens in the datapath via pcwritecond; zero is not needed here.
  assign unused_zero = zero;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:    if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = funct_ok ? S_RTYPE_EX : S_HALT;
          OP_BEQ:          state_d = S_BEQ;
          OP_ADDI, OP_ORI: state_d = S_IMM_EX;
          OP_LUI:          state_d = S_LUI_WB;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_HALT;
        endcase
        if (state_d == S_HALT) err_d = 2'b01;
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (memready) state_d = S_MEMWB;
      S_MEMWR:    if (memready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    // A ready in the same cycle the limit is hit still completes the access.
    if (mem_state && !memready) begin
      if ((WAIT_LIMIT != 0) && ((32'(wait_q) + 32'd1) >= WAIT_LIMIT)) begin
        state_d = S_HALT;
        err_d   = 2'b10;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (state_d != state_q) wait_d = '0;
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH:  ctrl_d = CTRL_FETCH;
      S_DECODE: begin
        ctrl_d.alusrcb    = 2'b11;
        ctrl_d.alucontrol = 3'b010;
      end
      S_MEMADR: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = 2'b10;
        ctrl_d.alucontrol = 3'b010;
      end
      S_MEMRD: begin
        ctrl_d.memreq = 1'b1;
        ctrl_d.iord   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.memtoreg = 2'b01;
        ctrl_d.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.memreq   = 1'b1;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alucontrol = funct_alu;
      end
      S_RTYPE_WB: begin
        ctrl_d.regdst   = 1'b1;
        ctrl_d.regwrite = 1'b1;
      end
      S_BEQ: begin
        ctrl_d.alusrca     = 1'b1;
        ctrl_d.alucontrol  = 3'b110;
        ctrl_d.pcwritecond = 1'b1;
        ctrl_d.pcsrc       = 2'b01;
      end
      S_IMM_EX: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = 2'b10;
        ctrl_d.alucontrol = (op == OP_ORI) ? 3'b001 : 3'b010;
        ctrl_d.immzext    = (op == OP_ORI);
      end
      S_IMM_WB: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.immzext  = ctrl_q.immzext;
      end
      S_LUI_WB: begin
        ctrl_d.memtoreg = 2'b10;
        ctrl_d.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pcwrite = 1'b1;
        ctrl_d.pcsrc   = 2'b10;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 2'b00;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign memreq      = ctrl_q.memreq;
  assign memwrite    = ctrl_q.memwrite;
  assign iord        = ctrl_q.iord;
  assign irwrite     = ctrl_q.fetch & memready;
  assign pcwrite     = ctrl_q.pcwrite | (ctrl_q.fetch & memready);
  assign pcwritecond = ctrl_q.pcwritecond;
  assign pcsrc       = ctrl_q.pcsrc;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign alucontrol  = ctrl_q.alucontrol;
  assign immzext     = ctrl_q.immzext;
  assign regdst      = ctrl_q.regdst;
  assign memtoreg    = ctrl_q.memtoreg;
  assign regwrite    = ctrl_q.regwrite;
  assign halted      = ctrl_q.halted;
  assign errcode     = err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle comparison of the full control
// vector against hand-written per-state constants.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memreq, memwrite, iord, irwrite, pcwrite, pcwritecond;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       immzext, regdst;
  logic [1:0] memtoreg;
  logic       regwrite, halted;
  logic [1:0] errcode;

  int n_vec = 0;
  int n_err = 0;
  int pcw_cnt;

  logic [21:0] obs;
  logic [21:0] F1, F0, DEC, MADR, MRD, MWB, MWR, RSUB, RAND, RWB, BEQV;
  logic [21:0] IORI, WORI, IADD, WADD, LUIW, JMP, H01, H10;

  multicycle_controller #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .immzext(immzext), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .halted(halted), .errcode(errcode)
  );

  always #5 clk = ~clk;

  assign obs = {memreq, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsrc, alusrca,
                alusrcb, alucontrol, immzext, regdst, memtoreg, regwrite, halted, errcode};

  function automatic logic [21:0] mk(input logic mr, mw, io, ir, pw, pwc,
                                     input logic [1:0] ps, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] alu,
                                     input logic iz, rd, input logic [1:0] m2r,
                                     input logic rw, hl, input logic [1:0] ec);
    return {mr, mw, io, ir, pw, pwc, ps, asa, asb, alu, iz, rd, m2r, rw, hl, ec};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [21:0] expv);
    memready = rdy;
    #1;
    chk(tag, {10'd0, obs}, {10'd0, expv});
    pcw_cnt += int'(pcwrite);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    memready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    F1   = mk(1,0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,2'b00,0,0,2'b00);
    F0   = mk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,2'b00,0,0,2'b00);
    DEC  = mk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,2'b00,0,0,2'b00);
    MADR = mk(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,2'b00,0,0,2'b00);
    MRD  = mk(1,0,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b00,0,0,2'b00);
    MWB  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b01,1,0,2'b00);
    MWR  = mk(1,1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b00,0,0,2'b00);
    RSUB = mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b110,0,0,2'b00,0,0,2'b00);
    RAND = mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b000,0,0,2'b00,0,0,2'b00);
    RWB  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,2'b00,1,0,2'b00);
    BEQV = mk(0,0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,2'b00,0,0,2'b00);
    IORI = mk(0,0,0,0,0,0,2'b00,1,2'b10,3'b001,1,0,2'b00,0,0,2'b00);
    WORI = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,2'b00,1,0,2'b00);
    IADD = mk(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,2'b00,0,0,2'b00);
    WADD = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b00,1,0,2'b00);
    LUIW = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b10,1,0,2'b00);
    JMP  = mk(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,0,0,2'b00,0,0,2'b00);
    H01  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b00,0,1,2'b01);
    H10  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,2'b00,0,1,2'b10);

    op = 6'b000000; funct = 6'b000000; zero = 1'b0; memready = 1'b0; reset = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_state", {10'd0, obs}, {10'd0, F0});
    reset = 1'b0;

    // R-type sub: 4 cycles, single pcwrite pulse.
    op = 6'b000000; funct = 6'b100010; pcw_cnt = 0;
    cyc("sub_fetch", 1'b1, F1);
    cyc("sub_dec",   1'b1, DEC);
    cyc("sub_ex",    1'b1, RSUB);
    cyc("sub_wb",    1'b1, RWB);
    chk("sub_pcw_once", pcw_cnt, 1);
    $display("txn sub    cycles=4");

    // R-type and.
    funct = 6'b100100;
    cyc("and_fetch", 1'b1, F1);
    cyc("and_dec",   1'b1, DEC);
    cyc("and_ex",    1'b1, RAND);
    cyc("and_wb",    1'b1, RWB);
    $display("txn and    cycles=4");

    // lw with 3 stall cycles in MEMRD: 8 cycles total.
    op = 6'b100011;
    cyc("lw_fetch", 1'b1, F1);
    cyc("lw_dec",   1'b1, DEC);
    cyc("lw_adr",   1'b1, MADR);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, MRD);
    cyc("lw_rd",    1'b1, MRD);
    cyc("lw_wb",    1'b1, MWB);
    $display("txn lw     cycles=8");

    // sw with stalls in FETCH and MEMWR; counter must clear between them.
    op = 6'b101011;
    cyc("sw_fetch_wait", 1'b0, F0);
    cyc("sw_fetch_wait", 1'b0, F0);
    cyc("sw_fetch", 1'b1, F1);
    cyc("sw_dec",   1'b1, DEC);
    cyc("sw_adr",   1'b1, MADR);
    for (int i = 0; i < 3; i++) cyc("sw_wr_wait", 1'b0, MWR);
    cyc("sw_wr",    1'b1, MWR);
    $display("txn sw     cycles=9");

    op = 6'b001101;
    cyc("ori_fetch", 1'b1, F1);
    cyc("ori_dec",   1'b1, DEC);
    cyc("ori_ex",    1'b1, IORI);
    cyc("ori_wb",    1'b1, WORI);
    $display("txn ori    cycles=4");

    op = 6'b001111;
    cyc("lui_fetch", 1'b1, F1);
    cyc("lui_dec",   1'b1, DEC);
    cyc("lui_wb",    1'b1, LUIW);
    $display("txn lui    cycles=3");

    op = 6'b001000;
    cyc("addi_fetch", 1'b1, F1);
    cyc("addi_dec",   1'b1, DEC);
    cyc("addi_ex",    1'b1, IADD);
    cyc("addi_wb",    1'b1, WADD);
    $display("txn addi   cycles=4");

    op = 6'b000100; zero = 1'b1;
    cyc("beq_fetch", 1'b1, F1);
    cyc("beq_dec",   1'b1, DEC);
    cyc("beq_ex",    1'b1, BEQV);
    $display("txn beq    cycles=3");

    op = 6'b000010; zero = 1'b0;
    cyc("j_fetch", 1'b1, F1);
    cyc("j_dec",   1'b1, DEC);
    cyc("j_ex",    1'b1, JMP);
    cyc("j_next",  1'b1, F1);
    $display("txn j      cycles=3");

    // Illegal opcode: halt for 20 cycles, then reset recovers.
    op = 6'b111111;
    cyc("ill_dec", 1'b1, DEC);
    for (int i = 0; i < 20; i++) cyc("ill_halt", i[0], H01);
    do_reset();
    cyc("ill_rst", 1'b0, F0);
    $display("txn illop  halted");

    // Illegal R-type funct.
    op = 6'b000000; funct = 6'b000000;
    cyc("badf_fetch", 1'b1, F1);
    cyc("badf_dec",   1'b1, DEC);
    cyc("badf_halt",  1'b1, H01);
    do_reset();
    $display("txn badfn  halted");

    // Memory timeout in FETCH after 4 low cycles.
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1'b0, F0);
    cyc("to_halt", 1'b0, H10);
    do_reset();
    $display("txn tmout  halted");

    // Ready arriving on the 4th cycle wins over the limit.
    op = 6'b000010;
    for (int i = 0; i < 3; i++) cyc("rdy_fetch_wait", 1'b0, F0);
    cyc("rdy_fetch", 1'b1, F1);
    cyc("rdy_dec",   1'b1, DEC);
    cyc("rdy_jump",  1'b1, JMP);
    $display("txn rdywin cycles=6");

    // Reset in the middle of a stalled store.
    op = 6'b101011;
    cyc("rw_fetch", 1'b1, F1);
    cyc("rw_dec",   1'b1, DEC);
    cyc("rw_adr",   1'b1, MADR);
    memready = 1'b0; reset = 1'b1;
    #1;
    chk("rw_mwr", {10'd0, obs}, {10'd0, MWR});
    tick();
    reset = 1'b0;
    cyc("rw_after_rst", 1'b0, F0);
    $display("txn swrst  aborted");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
